cpu_control_unit: RTL and testbench
===================================

// Module: cpu_control_unit
// PURPOSE
//  Multi-cycle control sequencer that drives the Integer_Datapath control inputs.
//  Fetches 16-bit instructions over a req/ack memory port and holds them in an IR.
//  Decodes opcodes into W_En/W_Adr/R_Adr/S_Adr/S_Sel/Alu_Op, owns the PC and latches C/N/Z.
//  Sits directly upstream of the datapath. Memory mux and DS wiring live at CPU top level.
// PARAMETERS
//  RESET_PC     16'h0000  PC value loaded on reset
//  MEM_TIMEOUT  16        max cycles mem_req may wait for mem_ack (CTRL_WATCHDOG_EN only)
// PORTS
//  clk           in   1   system clock, rising edge
//  reset         in   1   asynchronous, active-high reset
//  mem_req       out  1   memory request; held high until mem_ack
//  mem_we        out  1   1=write (store), 0=read; valid while mem_req=1
//  mem_addr_sel  out  1   0: address=pc, 1: address=Reg_Out (datapath R port)
//  mem_ack       in   1   one-cycle acknowledge; mem_rdata valid in that cycle
//  mem_rdata     in   16  instruction word during fetch
//  pc            out  16  program counter
//  W_En          out  1   datapath register write enable (one-cycle pulse)
//  W_Adr         out  3   datapath write address = IR[11:9]
//  R_Adr         out  3   datapath R read address = IR[8:6]
//  S_Adr         out  3   datapath S read address = IR[5:3]
//  S_Sel         out  1   1 selects DS (memory load data) into ALU S input
//  Alu_Op        out  4   ALU operation
//  C, N, Z       in   1   datapath ALU flags (combinational)
//  flags         out  3   latched {C,N,Z}
//  halted        out  1   1 in HALT state
//  fault         out  1   watchdog fault, sticky until reset
// BEHAVIOUR
//  Reset (async): state=FETCH, pc=RESET_PC, IR=0, flags=0, halted=0, fault=0.
//    All control outputs are 0 at reset.
//  Instruction format: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [8:0] branch offset.
//  Op decode:
//    0x0-0xB  ALU op; Alu_Op = op
//    0xC      LOAD  rd <= mem[rs]
//    0xD      STORE mem[rs] <= rt
//    0xE      BR, condition code in rd: 0=always, 1=Z, 2=N, 3=C, 4=!Z
//    0xF      HALT
//  Control outputs are Moore-decoded from state+IR. No outputs change mid-state except on mem_ack.
//  FSM: FETCH -> DECODE -> {EXEC | MEM | BRANCH | HALT} -> FETCH.
//  FETCH: mem_req=1, mem_we=0, mem_addr_sel=0.
//    On mem_ack: IR<=mem_rdata, pc<=pc+1 (wraps 16'hFFFF->0).
//    Stays in FETCH while mem_ack=0.
//  DECODE: 1 cycle, no side effects; R/S/W addresses already driven from IR.
//  EXEC (ALU ops): W_En=1, S_Sel=0 for exactly one cycle. flags<={C,N,Z} at end of cycle.
//    Total 3 cycles with zero-wait memory.
//  MEM LOAD: mem_req=1, mem_addr_sel=1, mem_we=0.
//    In the ack cycle: S_Sel=1, Alu_Op=ALU_PASS_S, W_En=1. flags are not updated.
//  MEM STORE: mem_req=1, mem_we=1, mem_addr_sel=1, S_Sel=0, Alu_Op=ALU_PASS_S, W_En=0.
//    Alu_Out is the write data. Completes on mem_ack.
//  BRANCH: 1 cycle. If condition true against latched flags: pc<=pc+sext(IR[8:0]).
//    The PC already points past the branch. Undefined cond codes 5-7 mean not taken.
//  HALT: halted=1 and all enables 0. Only reset exits this state.
//  mem_ack outside FETCH/MEM is ignored. mem_req never drops before ack.
//  Reset mid-transaction drops mem_req at once. The memory side must tolerate an abandoned request.
// CONFIGURATION
//  `CTRL_WATCHDOG_EN defined:
//    A counter runs while mem_req=1 and mem_ack=0.
//    When it reaches MEM_TIMEOUT: mem_req drops, fault=1, state=HALT.
//    The counter clears on ack or on state change.
//  `CTRL_WATCHDOG_EN undefined: no counter, fault tied to 0, waits indefinitely.
// STRUCTURE
//  cpu_defs.vh (shared include): opcode constants, ALU op codes (incl. ALU_PASS_S),
//    branch condition codes, FSM state encodings.
//  Integer_Datapath and the ALU include the same file.
//  One sub-module, cu_watchdog (counter + compare), instantiated only under CTRL_WATCHDOG_EN.
//  Decode logic stays inline.
// TESTING
//  1. Reset mid-FETCH: mem_req=0 and pc=RESET_PC at once. Next cycle: mem_req=1, mem_addr_sel=0.
//  2. Fetch 16'h1250 (op1, rd=1, rs=1, rt=2), ack in 1st cycle:
//     W_En pulses in 3rd cycle with W_Adr=1, R_Adr=1, S_Adr=2, Alu_Op=1.
//     Drive Z=1: flags=3'b001 after.
//  3. LOAD 16'hC680 with ack delayed 4 cycles:
//     mem_req held 5 cycles with mem_addr_sel=1. W_En=1 and S_Sel=1 only in the ack cycle, W_Adr=3.
//  4. BR Z (16'hE3FC) at pc=10 with flags.Z=1: next fetch pc=7.
//     Same with Z=0: next fetch pc=11. Also pc=16'hFFFF fetch wraps to 0.
//  5. STORE: mem_we=1, W_En=0, Alu_Op=ALU_PASS_S. HALT 16'hF000: halted=1 and no further mem_req.
//  6. With CTRL_WATCHDOG_EN and mem_ack tied low: fault=1 and halted=1 after MEM_TIMEOUT cycles.
//     Without the macro: mem_req stays high and fault=0.

Source files
------------

// File: rtl/cpu_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// cpu_control_unit_pkg
// Shared definitions for the control sequencer: FSM state encoding, opcode
// constants, ALU operation codes used by the sequencer itself, branch
// condition codes and the branch-condition evaluation helper.
// Ports: none (package).
// ---------------------------------------------------------------------------
package cpu_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_BRANCH = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Opcodes 0x0..0xB are ALU operations passed straight to Alu_Op.
  localparam logic [3:0] OP_LOAD  = 4'hC;
  localparam logic [3:0] OP_STORE = 4'hD;
  localparam logic [3:0] OP_BR    = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU code that routes the S input straight to Alu_Out.
  localparam logic [3:0] ALU_PASS_S = 4'hC;

  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_Z      = 3'd1;
  localparam logic [2:0] COND_N      = 3'd2;
  localparam logic [2:0] COND_C      = 3'd3;
  localparam logic [2:0] COND_NZ     = 3'd4;

  // flags are packed {C,N,Z}; codes 5-7 are never taken.
  function automatic logic branch_taken(input logic [2:0] cond,
                                        input logic [2:0] flags);
    logic taken;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_Z:      taken = flags[0];
      COND_N:      taken = flags[1];
      COND_C:      taken = flags[2];
      COND_NZ:     taken = ~flags[0];
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/cpu_control_unit_watchdog.sv
// ---------------------------------------------------------------------------
// cu_watchdog
// Counts consecutive cycles a memory request waits without acknowledge and
// flags expiry on the MEM_TIMEOUT-th waiting cycle.
// Ports:
//   clk        in  system clock, rising edge
//   reset      in  asynchronous active-high reset
//   i_wait     in  request outstanding and not acknowledged this cycle
//   i_clear    in  sequencer changes state this cycle
//   o_expired  out this is the MEM_TIMEOUT-th consecutive waiting cycle
// ---------------------------------------------------------------------------
module cu_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wait,
  input  logic i_clear,
  output logic o_expired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear || !i_wait) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  // r_count holds the number of earlier waiting cycles.
  assign o_expired = i_wait && (r_count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_control_unit.sv
// ---------------------------------------------------------------------------
// cpu_control_unit
// Multi-cycle sequencer for the Integer_Datapath: fetches 16-bit
// instructions over a req/ack port into the IR, decodes them into datapath
// controls, owns the PC and latches the ALU flags.
// Optional feature macro: CTRL_WATCHDOG_EN (memory wait watchdog -> fault).
// Ports:
//   clk, reset                     clock / async active-high reset
//   mem_req, mem_we, mem_addr_sel  memory request, write, address select
//   mem_ack, mem_rdata             memory acknowledge and read data
//   pc                             program counter
//   W_En, W_Adr, R_Adr, S_Adr      datapath register file controls
//   S_Sel, Alu_Op                  datapath S-input select and ALU op
//   C, N, Z                        datapath ALU flags (combinational)
//   flags                          latched {C,N,Z}
//   halted, fault                  HALT state, sticky watchdog fault
// ---------------------------------------------------------------------------
module cpu_control_unit
  import cpu_control_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] pc,
  output logic        W_En,
  output logic [2:0]  W_Adr,
  output logic [2:0]  R_Adr,
  output logic [2:0]  S_Adr,
  output logic        S_Sel,
  output logic [3:0]  Alu_Op,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic [2:0]  flags,
  output logic        halted,
  output logic        fault
);

  state_t      r_state, w_state_next;
  logic [15:0] r_pc, w_pc_next;
  logic [15:0] r_ir, w_ir_next;
  logic [2:0]  r_flags, w_flags_next;
  // Low for the first cycle after reset so no request is raised while in reset.
  logic        r_run;
  logic [3:0]  w_op;
  logic        w_expired;

  assign w_op = r_ir[15:12];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_flags <= '0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
      r_flags <= w_flags_next;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    w_flags_next = r_flags;
    case (r_state)
      ST_FETCH: begin
        if (r_run && mem_ack) begin
          w_ir_next    = mem_rdata;
          w_pc_next    = r_pc + 16'd1;
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (w_op)
          OP_LOAD, OP_STORE: w_state_next = ST_MEM;
          OP_BR:             w_state_next = ST_BRANCH;
          OP_HALT:           w_state_next = ST_HALT;
          default:           w_state_next = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        w_flags_next = {C, N, Z};
        w_state_next = ST_FETCH;
      end
      ST_MEM: begin
        if (mem_ack) w_state_next = ST_FETCH;
      end
      ST_BRANCH: begin
        // PC already points past the branch; offset is relative to that.
        if (branch_taken(r_ir[11:9], r_flags))
          w_pc_next = r_pc + {{7{r_ir[8]}}, r_ir[8:0]};
        w_state_next = ST_FETCH;
      end
      default: w_state_next = ST_HALT;
    endcase
    if (w_expired) w_state_next = ST_HALT;
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    W_En         = 1'b0;
    S_Sel        = 1'b0;
    Alu_Op       = 4'h0;
    halted       = 1'b0;
    case (r_state)
      ST_FETCH: mem_req = r_run;
      ST_EXEC: begin
        W_En   = 1'b1;
        Alu_Op = w_op;
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        Alu_Op       = ALU_PASS_S;
        if (w_op == OP_STORE) begin
          mem_we = 1'b1;
        end else begin
          // Load data is only valid in the ack cycle: write it through S.
          W_En  = mem_ack;
          S_Sel = mem_ack;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign pc    = r_pc;
  assign flags = r_flags;
  assign W_Adr = r_ir[11:9];
  assign R_Adr = r_ir[8:6];
  assign S_Adr = r_ir[5:3];

`ifdef CTRL_WATCHDOG_EN
  logic w_wait;
  logic w_clear;
  logic r_fault;

  assign w_wait  = mem_req & ~mem_ack;
  assign w_clear = (w_state_next != r_state);

  cu_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_wait   (w_wait),
    .i_clear  (w_clear),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_fault <= 1'b0;
    else if (w_expired) r_fault <= 1'b1;
  end

  assign fault = r_fault;
`else
  assign w_expired = 1'b0;
  // No watchdog: fault is constant 0 (MEM_TIMEOUT is a positive count).
  assign fault = (MEM_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;
  import cpu_control_unit_pkg::*;

  localparam int TIMEOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_addr_sel, mem_ack;
  logic [15:0] mem_rdata, pc;
  logic        W_En, S_Sel, C, N, Z, halted, fault;
  logic [2:0]  W_Adr, R_Adr, S_Adr, flags;
  logic [3:0]  Alu_Op;

  int vectors = 0;
  int miscompares = 0;

  // Reference architectural state.
  logic [15:0] m_pc;
  logic [2:0]  m_flags;
  bit          g_skip_edge;

  typedef struct {
    int          fetch_bad;
    logic [15:0] fetch_pc;
    int          wen_cnt;
    int          wen_idx;
    logic [8:0]  wen_adr;
    logic [3:0]  wen_op;
    logic        wen_ssel;
    int          ssel_cnt;
    int          mreq_cnt;
    int          mwe_cnt;
    int          mop_bad;
    int          cycles;
    bit          next_fetch;
    logic [15:0] pc_end;
    logic [2:0]  flags_end;
  } obs_t;

  typedef struct {
    logic [15:0] pc_next;
    logic [2:0]  flags;
    int          wen_cnt;
    int          wen_idx;
    int          mreq_cnt;
    int          mwe_cnt;
    int          ssel_cnt;
    int          cycles;
  } exp_t;

  cpu_control_unit #(.RESET_PC(16'h0000), .MEM_TIMEOUT(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc(pc), .W_En(W_En), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
    .S_Sel(S_Sel), .Alu_Op(Alu_Op), .C(C), .N(N), .Z(Z), .flags(flags),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Architectural effect of one instruction, from the instruction-set rules.
  function automatic exp_t model(input logic [15:0] ins, input logic [2:0] cnz, input int mw);
    exp_t e;
    logic [3:0]  op;
    logic [15:0] seq;
    logic        take;
    e = '{default:0};
    op = ins[15:12];
    seq = m_pc + 16'd1;
    e.pc_next = seq;
    e.flags = m_flags;
    e.cycles = 3;
    if (op <= 4'hB) begin
      e.wen_cnt = 1; e.wen_idx = 2; e.flags = cnz;
    end else if (op == 4'hC) begin
      e.wen_cnt = 1; e.wen_idx = 2 + mw; e.mreq_cnt = mw + 1; e.ssel_cnt = 1; e.cycles = 3 + mw;
    end else if (op == 4'hD) begin
      e.mreq_cnt = mw + 1; e.mwe_cnt = mw + 1; e.cycles = 3 + mw;
    end else if (op == 4'hE) begin
      case (ins[11:9])
        3'd0: take = 1'b1;
        3'd1: take = m_flags[0];
        3'd2: take = m_flags[1];
        3'd3: take = m_flags[2];
        3'd4: take = !m_flags[0];
        default: take = 1'b0;
      endcase
      if (take) e.pc_next = seq + {{7{ins[8]}}, ins[8:0]};
    end
    return e;
  endfunction

  // Memory/flag driver: serves one fetch and its execution, records what it saw.
  task automatic run_instr(input logic [15:0] ins, input int fw, input int mw,
                           input logic [2:0] cnz, input bit spur, input int limit,
                           output obs_t o);
    int fcnt = 0, mcnt = 0, idx = 0;
    bit ph = 0;
    o = '{default:0};
    for (int cyc = 0; cyc < limit; cyc++) begin
      if (!(cyc == 0 && g_skip_edge)) @(negedge clk);
      g_skip_edge = 0;
      mem_ack = 1'b0;
      mem_rdata = 16'($urandom);
      {C, N, Z} = cnz;
      if (ph) begin
        idx++;
        if (mem_req && !mem_addr_sel) begin
          o.next_fetch = 1;
          g_skip_edge = 1;
          break;
        end
        if (mem_req) begin
          o.mreq_cnt++;
          if (mem_we) o.mwe_cnt++;
          if (Alu_Op !== ALU_PASS_S) o.mop_bad++;
          if (mcnt == mw) mem_ack = 1'b1;
          mcnt++;
        end else if (spur) begin
          mem_ack = 1'b1;
        end
      end else if (mem_req) begin
        if (mem_addr_sel || mem_we) o.fetch_bad++;
        if (fcnt == fw) begin
          mem_ack = 1'b1;
          mem_rdata = ins;
          o.fetch_pc = pc;
        end
        fcnt++;
      end
      #1;
      if (W_En === 1'b1) begin
        o.wen_cnt++; o.wen_idx = idx; o.wen_adr = {W_Adr, R_Adr, S_Adr};
        o.wen_op = Alu_Op; o.wen_ssel = S_Sel;
      end
      if (S_Sel === 1'b1) o.ssel_cnt++;
      if (!ph && mem_ack) ph = 1;
    end
    o.cycles = idx;
    o.pc_end = pc;
    o.flags_end = flags;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0; {C, N, Z} = 3'b000;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    m_pc = 16'h0000; m_flags = 3'b000; g_skip_edge = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0; {C, N, Z} = 3'b000;
    #1;
    vectors++;
    if ({mem_req, mem_we, mem_addr_sel, W_En, S_Sel, Alu_Op} !== 9'd0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 0", {mem_req, mem_we, mem_addr_sel, W_En, S_Sel, Alu_Op});
    end
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({pc, flags, halted, fault, mem_req} !== 22'd0) begin
      miscompares++; $display("FAIL reset_state: got pc=%h flags=%b h=%b f=%b req=%b want all 0", pc, flags, halted, fault, mem_req);
    end
    reset = 1'b0;
    m_pc = 16'h0000; m_flags = 3'b000; g_skip_edge = 0;
  endtask

  task automatic test_reset_mid_fetch();
    obs_t o;
    run_instr({4'h3, 12'($urandom)}, 0, 0, 3'b010, 0, 30, o);
    vectors++;
    if (!(o.next_fetch && mem_req === 1'b1 && pc === 16'h0001)) begin
      miscompares++; $display("FAIL mid_fetch_setup: got req=%b pc=%h want req=1 pc=0001", mem_req, pc);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || pc !== 16'h0000) begin
      miscompares++; $display("FAIL mid_fetch_reset: got req=%b pc=%h want req=0 pc=0000", mem_req, pc);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1 || mem_addr_sel !== 1'b0) begin
      miscompares++; $display("FAIL mid_fetch_restart: got req=%b sel=%b want req=1 sel=0", mem_req, mem_addr_sel);
    end
    m_pc = 16'h0000; m_flags = 3'b000; g_skip_edge = 1;
  endtask

  task automatic test_alu_directed();
    obs_t o;
    run_instr(16'h1250, 0, 0, 3'b001, 0, 30, o);
    vectors++;
    if (o.wen_cnt != 1 || o.wen_idx != 2) begin
      miscompares++; $display("FAIL alu_wen_timing: got cnt=%0d idx=%0d want cnt=1 idx=2", o.wen_cnt, o.wen_idx);
    end
    vectors++;
    if ({o.wen_adr, o.wen_op} !== {3'd1, 3'd1, 3'd2, 4'd1}) begin
      miscompares++; $display("FAIL alu_fields: got adr=%o op=%h want adr=112 op=1", o.wen_adr, o.wen_op);
    end
    vectors++;
    if (o.flags_end !== 3'b001) begin
      miscompares++; $display("FAIL alu_flags: got %b want 001", o.flags_end);
    end
    m_pc = m_pc + 16'd1; m_flags = 3'b001;
  endtask

  task automatic test_load();
    obs_t o;
    exp_t e;
    e = model(16'hC680, 3'b111, 4);
    run_instr(16'hC680, 0, 4, 3'b111, 1, 30, o);
    vectors++;
    if (o.mreq_cnt != 5 || o.mop_bad != 0 || o.mwe_cnt != 0) begin
      miscompares++; $display("FAIL load_req: got req=%0d opbad=%0d we=%0d want 5/0/0", o.mreq_cnt, o.mop_bad, o.mwe_cnt);
    end
    vectors++;
    if (o.wen_cnt != 1 || o.wen_idx != 6 || o.ssel_cnt != 1 || o.wen_ssel !== 1'b1) begin
      miscompares++; $display("FAIL load_wen: got cnt=%0d idx=%0d ssel=%0d want 1/6/1", o.wen_cnt, o.wen_idx, o.ssel_cnt);
    end
    vectors++;
    if (o.wen_adr[8:6] !== 3'd3 || o.flags_end !== e.flags) begin
      miscompares++; $display("FAIL load_adr_flags: got wadr=%0d flags=%b want 3 %b", o.wen_adr[8:6], o.flags_end, e.flags);
    end
    m_pc = e.pc_next;
  endtask

  task automatic test_store();
    obs_t o;
    int mw = int'($urandom_range(1, 3));
    logic [15:0] ins = {4'hD, 12'($urandom)};
    run_instr(ins, 1, mw, 3'($urandom), 0, 30, o);
    vectors++;
    if (o.mwe_cnt != mw + 1 || o.mreq_cnt != mw + 1 || o.wen_cnt != 0 || o.mop_bad != 0) begin
      miscompares++; $display("FAIL store: got we=%0d req=%0d wen=%0d opbad=%0d want we=req=%0d wen=0", o.mwe_cnt, o.mreq_cnt, o.wen_cnt, o.mop_bad, mw + 1);
    end
    m_pc = m_pc + 16'd1;
  endtask

  task automatic test_branch();
    obs_t o;
    logic [15:0] off;
    for (int k = 0; k < 2; k++) begin
      logic zv = (k == 0);
      run_instr({4'h2, 12'($urandom)}, 0, 0, {2'b00, zv}, 0, 30, o);
      m_pc = m_pc + 16'd1; m_flags = {2'b00, zv};
      off = 16'd10 - (m_pc + 16'd1);
      run_instr({4'hE, 3'd0, off[8:0]}, 0, 0, 3'b000, 1, 30, o);
      m_pc = 16'd10;
      run_instr(16'hE3FC, 0, 0, 3'b000, 0, 30, o);
      vectors++;
      if (o.fetch_pc !== 16'd10 || o.pc_end !== (zv ? 16'd7 : 16'd11)) begin
        miscompares++; $display("FAIL br_z%0d: got at=%0d next=%0d want at=10 next=%0d", zv, o.fetch_pc, o.pc_end, zv ? 7 : 11);
      end
      m_pc = zv ? 16'd7 : 16'd11;
    end
  endtask

  task automatic test_wrap();
    obs_t o;
    do_reset();
    run_instr(16'hE1FE, 0, 0, 3'b000, 0, 30, o);
    run_instr({4'h5, 12'($urandom)}, 0, 0, 3'b100, 0, 30, o);
    vectors++;
    if (o.fetch_pc !== 16'hFFFF || o.pc_end !== 16'h0000) begin
      miscompares++; $display("FAIL pc_wrap: got at=%h next=%h want FFFF 0000", o.fetch_pc, o.pc_end);
    end
    m_pc = 16'h0000; m_flags = 3'b100;
  endtask

  task automatic test_random_mix();
    obs_t o;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ins = {4'($urandom_range(0, 14)), 12'($urandom)};
      logic [2:0]  cnz = 3'($urandom);
      int fw = int'($urandom_range(0, 3));
      int mw = int'($urandom_range(0, 3));
      e = model(ins, cnz, mw);
      run_instr(ins, fw, mw, cnz, bit'($urandom_range(0, 1)), 30, o);
      vectors++;
      if (!o.next_fetch || o.fetch_pc !== m_pc || o.pc_end !== e.pc_next || o.fetch_bad != 0) begin
        miscompares++; $display("FAIL mix_pc[%0d] ins=%h: got at=%h next=%h want at=%h next=%h", i, ins, o.fetch_pc, o.pc_end, m_pc, e.pc_next);
      end
      vectors++;
      if (o.flags_end !== e.flags || o.wen_cnt != e.wen_cnt || o.ssel_cnt != e.ssel_cnt) begin
        miscompares++; $display("FAIL mix_wr[%0d] ins=%h: got fl=%b wen=%0d ssel=%0d want fl=%b wen=%0d ssel=%0d", i, ins, o.flags_end, o.wen_cnt, o.ssel_cnt, e.flags, e.wen_cnt, e.ssel_cnt);
      end
      vectors++;
      if (o.mreq_cnt != e.mreq_cnt || o.mwe_cnt != e.mwe_cnt || o.cycles != e.cycles ||
          (e.wen_cnt == 1 && (o.wen_idx != e.wen_idx || o.wen_adr !== ins[11:3]))) begin
        miscompares++; $display("FAIL mix_seq[%0d] ins=%h: got req=%0d we=%0d cyc=%0d want req=%0d we=%0d cyc=%0d", i, ins, o.mreq_cnt, o.mwe_cnt, o.cycles, e.mreq_cnt, e.mwe_cnt, e.cycles);
      end
      m_pc = e.pc_next; m_flags = e.flags;
    end
  endtask

  task automatic test_halt();
    obs_t o;
    run_instr(16'hF000, 0, 0, 3'b111, 1, 12, o);
    vectors++;
    if (o.next_fetch || halted !== 1'b1 || o.mreq_cnt != 0 || o.wen_cnt != 0) begin
      miscompares++; $display("FAIL halt: got nf=%0d halted=%b req=%0d wen=%0d want 0/1/0/0", o.next_fetch, halted, o.mreq_cnt, o.wen_cnt);
    end
  endtask

  task automatic test_watchdog();
    int reqs = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) reqs++;
    end
`ifdef CTRL_WATCHDOG_EN
    vectors++;
    if (reqs != TIMEOUT_CYC || fault !== 1'b1 || halted !== 1'b1) begin
      miscompares++; $display("FAIL watchdog: got req=%0d fault=%b halted=%b want %0d/1/1", reqs, fault, halted, TIMEOUT_CYC);
    end
`else
    vectors++;
    if (reqs != 40 || fault !== 1'b0 || halted !== 1'b0) begin
      miscompares++; $display("FAIL no_watchdog: got req=%0d fault=%b halted=%b want 40/0/0", reqs, fault, halted);
    end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_reset_mid_fetch();
    test_alu_directed();
    test_load();
    test_store();
    test_branch();
    test_wrap();
    test_random_mix();
    test_halt();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
